// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for adder arbiters: id width helper, default widths,
// response slot encoding and a reusable response record.
package adder_arbiter_pkg;

  localparam int ADDER_N_DEFAULT = 32;
  localparam int NREQ_DEFAULT    = 4;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int arb_id_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  localparam int IDW_DEFAULT = arb_id_w(NREQ_DEFAULT);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic [IDW_DEFAULT-1:0]     id;
    logic [ADDER_N_DEFAULT-1:0] s;
    logic                       cout;
  } rsp_t;

endpackage

// File: rtl/adder_arbiter_adder.sv
// Shared unsigned adder: {cout, s} = a + b + cin over N bits.
module Adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] s_o,
  output logic         cout_o
);

  assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + (N+1)'(cin_i);

endmodule

// File: rtl/adder_arbiter_rr_grant.sv
// Round-robin grant: first valid requester searching upward from ptr,
// suppressed entirely when the downstream slot cannot take a result.
module rr_grant
  import adder_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = arb_id_w(NREQ)
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            slot_free_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_id_o,
  output logic            grant_any_o
);

  int   idx;
  logic found;

  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    found      = 1'b0;
    idx        = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (slot_free_i && !found && req_valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_id_o   = IDW'(idx);
        found        = 1'b1;
      end
    end
  end

  assign grant_any_o = found;

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one Adder among NREQ requesters, with a single
// registered response slot that supports back-to-back reload under backpressure.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter  int N    = ADDER_N_DEFAULT,
  parameter  int NREQ = NREQ_DEFAULT,
  localparam int IDW  = arb_id_w(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_s,
  output logic              rsp_cout
);

  slot_state_e     slot_q, slot_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [N-1:0]    rsp_s_q, rsp_s_d;
  logic            rsp_cout_q, rsp_cout_d;

  logic            slot_free;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic [N-1:0]    op_a, op_b;
  logic            op_cin;
  logic [N-1:0]    sum_s;
  logic            sum_cout;

  // Requests are ignored while reset is held so req_ready stays low.
  assign slot_free = rst_n & ((slot_q == SLOT_EMPTY) | rsp_ready);

  rr_grant #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_valid_i (req_valid),
    .ptr_i       (ptr_q),
    .slot_free_i (slot_free),
    .grant_o     (grant),
    .grant_id_o  (gnt_id),
    .grant_any_o (gnt_any)
  );

  assign req_ready = grant;

  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        op_a   = req_a[i*N +: N];
        op_b   = req_b[i*N +: N];
        op_cin = req_cin[i];
      end
    end
  end

  Adder #(
    .N (N)
  ) u_adder (
    .a_i    (op_a),
    .b_i    (op_b),
    .cin_i  (op_cin),
    .s_o    (sum_s),
    .cout_o (sum_cout)
  );

  always_comb begin
    slot_d     = slot_q;
    ptr_d      = ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_s_d    = rsp_s_q;
    rsp_cout_d = rsp_cout_q;
    if (gnt_any) begin
      slot_d     = SLOT_FULL;
      rsp_id_d   = gnt_id;
      rsp_s_d    = sum_s;
      rsp_cout_d = sum_cout;
      ptr_d      = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end else if (rsp_ready) begin
      slot_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= SLOT_EMPTY;
      ptr_q      <= '0;
      rsp_id_q   <= '0;
      rsp_s_q    <= '0;
      rsp_cout_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      ptr_q      <= ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_s_q    <= rsp_s_d;
      rsp_cout_q <= rsp_cout_d;
    end
  end

  assign rsp_valid = (slot_q == SLOT_FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: directed scenarios followed by random traffic.
module tb_adder_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_s;
  logic              rsp_cout;

  always #5 clk = ~clk;

  adder_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_s     (rsp_s),
    .rsp_cout  (rsp_cout)
  );

  typedef struct {
    int           id;
    logic [N-1:0] s;
    logic         cout;
  } exp_t;

  exp_t         exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [N-1:0] op_a[NREQ];
  logic [N-1:0] op_b[NREQ];
  logic         op_cin[NREQ];
  int           m_ptr  = 0;
  bit           m_full = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: one cycle of the arbiter described by its rules, not its gates.
  task automatic step(input logic [NREQ-1:0] v, input logic rr, output logic [NREQ-1:0] seen);
    int              g;
    logic [NREQ-1:0] er;
    logic [63:0]     tot;
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = op_a[i];
      req_b[i*N +: N] = op_b[i];
      req_cin[i]      = op_cin[i];
    end
    @(negedge clk);
    seen = req_ready;
    check("rsp_valid", 64'(rsp_valid), 64'(m_full));
    g  = -1;
    er = '0;
    if (!m_full || rr)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", 64'(seen), 64'(er));
    if (g >= 0) begin
      tot = 64'(op_a[g]) + 64'(op_b[g]) + 64'(op_cin[g]);
      exp_q.push_back('{g, tot[N-1:0], tot[N]});
      m_ptr  = (g + 1) % NREQ;
      m_full = 1'b1;
    end else if (rr) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id=%0d s=%0h, expected no response", rsp_id, rsp_s);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id",   64'(rsp_id),   64'(e.id));
        check("rsp_s",    64'(rsp_s),    64'(e.s));
        check("rsp_cout", 64'(rsp_cout), 64'(e.cout));
      end
    end
  end

  initial begin
    logic [NREQ-1:0] seen;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_cin[i] = 1'b0;
    end
    req_a = '0; req_b = '0; req_cin = '0;
    rsp_ready = 1'b1;
    req_valid = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 64'(rsp_valid), 0);
    check("reset_rsp_id",    64'(rsp_id),    0);
    check("reset_rsp_s",     64'(rsp_s),     0);
    check("reset_rsp_cout",  64'(rsp_cout),  0);
    check("reset_req_ready", 64'(req_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = '0;

    op_a[1] = 32'd5; op_b[1] = 32'd7; op_cin[1] = 1'b1;
    step(4'b0010, 1'b1, seen);
    check("single_ready", 64'(seen), 64'(4'b0010));
    check("single_valid", 64'(rsp_valid), 1);
    check("single_id",    64'(rsp_id),    1);
    check("single_s",     64'(rsp_s),     13);
    check("single_cout",  64'(rsp_cout),  0);

    op_a[2] = 32'hFFFF_FFFF; op_b[2] = 32'd1; op_cin[2] = 1'b0;
    step(4'b0100, 1'b1, seen);
    check("wrap1_s",    64'(rsp_s),    0);
    check("wrap1_cout", 64'(rsp_cout), 1);
    op_a[3] = 32'hFFFF_FFFF; op_b[3] = 32'hFFFF_FFFF; op_cin[3] = 1'b1;
    step(4'b1000, 1'b1, seen);
    check("wrap2_s",    64'(rsp_s),    64'h0000_0000_FFFF_FFFF);
    check("wrap2_cout", 64'(rsp_cout), 1);

    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = 32'(i * 100); op_b[i] = 32'(i + 1); op_cin[i] = i[0];
    end
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 1'b1, seen);
      check("rr_order", 64'(seen), 64'(1) << (k % NREQ));
    end

    for (int k = 0; k < 3; k++) begin
      step(4'b1111, 1'b0, seen);
      check("bp_ready_low", 64'(seen), 0);
    end
    step(4'b1111, 1'b1, seen);
    check("bp_release_grant", 64'(seen), 64'(4'b0001));

    step(4'b0010, 1'b1, seen);
    check("skip_g1", 64'(seen), 64'(4'b0010));
    step(4'b0001, 1'b1, seen);
    check("skip_g0", 64'(seen), 64'(4'b0001));
    step(4'b1001, 1'b1, seen);
    check("skip_g3", 64'(seen), 64'(4'b1000));

    step(4'b1111, 1'b0, seen);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(rsp_valid), 0);
    check("async_rst_s",     64'(rsp_s),     0);
    check("async_rst_id",    64'(rsp_id),    0);
    exp_q.delete();
    m_ptr  = 0;
    m_full = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b1111, 1'b1, seen);
    check("post_rst_grant", 64'(seen), 64'(4'b0001));

    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        op_a[i]   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        op_b[i]   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        op_cin[i] = $urandom_range(0, 1) == 1;
      end
      step(NREQ'($urandom), $urandom_range(0, 3) != 0, seen);
    end

    repeat (3) step(4'b0000, 1'b1, seen);
    check("drain_empty", 64'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter that shares one `Adder` datapath instance among `NREQ` requesters (e.g. PC increment, branch target, AGU) using valid/ready handshakes. Each accepted request passes once through the adder. The result, carry-out and requester id are returned through a single registered response slot with backpressure. The block sits between the pipeline stages that need additions and the single shared `Adder`.

## Interface
Parameters:
- `N`, 32, operand/result width; passed through to `Adder`
- `NREQ`, 4, number of requesters (≥2)
- `IDW`, `$clog2(NREQ)`, requester id width (derived, not overridden)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  per-requester request valid
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero
- `req_a`  in  NREQ*N  operand A; requester i occupies bits [i*N +: N]
- `req_b`  in  NREQ*N  operand B, same packing
- `req_cin`  in  NREQ  carry-in per requester
- `rsp_valid`  out  1  response slot holds a result
- `rsp_ready`  in  1  consumer accepts response
- `rsp_id`  out  IDW  index of the requester that produced the result
- `rsp_s`  out  N  sum, `(A + B + Cin) mod 2^N`
- `rsp_cout`  out  1  carry-out, bit N of `A + B + Cin`

## Operation
- Response slot has two states. EMPTY means `rsp_valid`=0. FULL means `rsp_valid`=1.
- `slot_free = !rsp_valid | rsp_ready`. A grant is possible only when `slot_free`=1.
- Round-robin pointer `ptr` (IDW bits) selects the search order. The grant goes to the first i with `req_valid[i]`=1, searching `ptr, ptr+1, … , ptr+NREQ-1` mod NREQ.
- `req_ready[g]`=1 only for the granted g, in the same cycle (combinational). The transfer occurs when both `req_valid[g]` and `req_ready[g]` are 1.
- On transfer:
  - the granted operands drive the shared `Adder`;
  - `{rsp_cout, rsp_s}` and `rsp_id`=g are loaded into the slot;
  - `rsp_valid`←1;
  - `ptr`←(g+1) mod NREQ.
- FULL with `rsp_ready`=1 and no new grant: `rsp_valid`←0.
- FULL with `rsp_ready`=1 and a grant in the same cycle: the slot is reloaded and `rsp_valid` stays 1. There are no bubbles.
- FULL with `rsp_ready`=0:
  - `req_ready`=0;
  - `rsp_*` held stable;
  - `ptr` unchanged.
- No valid requests: `ptr` is unchanged and no `req_ready` is asserted.
- `req_ready` never depends on `req_a`/`req_b`/`req_cin`.
- A requester may drop `req_valid` without a transfer. No state is kept for it.
- Arithmetic:
  - unsigned, full N+1-bit result;
  - wrap-around in `rsp_s`, with the overflow visible only on `rsp_cout`;
  - no signed-overflow flag.

## Timing
- Reset (async assert, sync release on `clk`):
  - `rsp_valid`=0, `rsp_id`=0, `rsp_s`=0, `rsp_cout`=0;
  - `ptr`=0;
  - `req_ready`=0, because `req_valid` is ignored during reset.
- Latency: request accepted at edge k gives `rsp_valid`=1 with its result after edge k, visible in cycle k+1.
- Throughput: 1 result per cycle while `rsp_ready`=1.
- Fairness: a continuously valid requester is granted within NREQ consecutive grants.
- Reset asserted mid-operation: a pending response is discarded, `rsp_valid` drops immediately (asynchronously), and the pointer returns to 0.
- The first grant after reset with all valid goes to requester 0.

## Structure
- Shared package holds:
  - the arbiter id width function/constant;
  - the default `N`;
  - a `rsp_t` struct {id, s, cout}, reusable by other arbiters.
- Sub-module: one instance of the existing `Adder` (`N`), fed by a grant-indexed operand mux.
- Recommended split: the round-robin priority logic as a separate `rr_grant` sub-module (inputs `req_valid`, `ptr`, `slot_free`; output one-hot grant), reusable elsewhere.

## Test plan
- Reset then single request: `req_valid`=0010, A=5, B=7, Cin=1 → `req_ready`=0010 in the same cycle; next cycle `rsp_valid`=1, `rsp_id`=1, `rsp_s`=13, `rsp_cout`=0.
- Wrap-around: A=0xFFFFFFFF, B=1, Cin=0 → `rsp_s`=0, `rsp_cout`=1. A=0xFFFFFFFF, B=0xFFFFFFFF, Cin=1 → `rsp_s`=0xFFFFFFFF, `rsp_cout`=1.
- All four valid continuously, `rsp_ready`=1 → grants 0,1,2,3,0,1… on consecutive cycles; `rsp_id` sequence matches, one cycle later.
- Backpressure: slot FULL, `rsp_ready`=0 for 3 cycles with requests pending → `req_ready`=0 and `rsp_*` stable. Raising `rsp_ready` → the old result is consumed and a new grant occurs in the same cycle.
- Pointer skip: last grant 1, `req_valid`=0001 → grant 0. Then `req_valid`=1001 → grant 3.
- Async reset while `rsp_valid`=1 mid-cycle → `rsp_valid` falls before the next edge. After release with `req_valid`=1111 → first grant is requester 0.
